// File: rtl/float_pkg.sv
// float_pkg: definitions shared by the bf16 arithmetic blocks (adders and
// converters): FSM state encoding, bf16 field layout, exponent bias and the
// int16 saturation constants.
package float_pkg;

    // Iterative converter states. The encoding is also exposed as a debug output.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // bf16 layout: sign[15], exponent[14:7], mantissa[6:0]
    localparam int BF16_W        = 16;
    localparam int BF16_SIGN_POS = 15;
    localparam int BF16_EXP_MSB  = 14;
    localparam int BF16_EXP_LSB  = 7;
    localparam int BF16_EXP_W    = 8;
    localparam int BF16_MAN_W    = 7;
    localparam int BF16_BIAS     = 127;

    localparam logic [BF16_EXP_W-1:0] BF16_EXP_ALL_ONES = 8'hFF;

    // -32768.0 is the one input whose exponent sits at the saturation
    // threshold but whose value still fits in int16.
    localparam logic [BF16_W-1:0] BF16_NEG_32768 = 16'hC700;

    localparam int INT16_W = 16;
    localparam logic [INT16_W-1:0] INT16_MAX = 16'h7FFF;
    localparam logic [INT16_W-1:0] INT16_MIN = 16'h8000;

endpackage

// File: rtl/bf16_to_int16_if.sv
// bf16_to_int16_if: operand/result handshake bundle of the bf16 -> int16
// converter.
//   a, in_valid   : operand and its valid (producer -> converter)
//   in_ready      : converter can take an operand
//   y, overflow   : int16 result and saturation/NaN flag
//   out_valid     : y/overflow valid
//   out_ready     : consumer takes the result
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. The sender holds its payload stable while valid is high and ready is
// low; valid does not depend combinationally on ready.
interface bf16_to_int16_if;
    import float_pkg::*;

    logic [BF16_W-1:0]  a;
    logic               in_valid;
    logic               in_ready;
    logic [INT16_W-1:0] y;
    logic               overflow;
    logic               out_valid;
    logic               out_ready;

    // master: the environment (operand producer and result consumer)
    modport master (
        output a, in_valid, out_ready,
        input  in_ready, y, overflow, out_valid
    );

    // slave: the converter
    modport slave (
        input  a, in_valid, out_ready,
        output in_ready, y, overflow, out_valid
    );

endinterface

// File: rtl/bf16_to_int16.sv
// bf16_to_int16: converts a bf16 operand to a two's-complement int16,
// truncating toward zero and saturating out-of-range values.
// The magnitude is aligned by a one-bit-per-cycle shift register, so the
// normal path takes n+2 edges (including the accept edge), where n is the
// distance of the exponent from BIAS+7; zero, |a|<1, NaN, infinity and
// out-of-range inputs complete on the accept edge.
//
// Ports:
//   clock   : rising-edge clock
//   reset   : synchronous, active-low reset
//   bus     : operand/result handshake (slave side)
//   state_o : current FSM state, for debug/observation
module bf16_to_int16
    import float_pkg::*;
#(
    parameter int BIAS = BF16_BIAS
) (
    input  logic                   clock,
    input  logic                   reset,
    bf16_to_int16_if.slave         bus,
    output state_t                 state_o
);

    // Exponent thresholds, widened by one bit so BIAS+15 cannot wrap.
    localparam logic [BF16_EXP_W:0] E_BIAS  = (BF16_EXP_W+1)'(BIAS);
    localparam logic [BF16_EXP_W:0] E_PIVOT = (BF16_EXP_W+1)'(BIAS + 7);
    localparam logic [BF16_EXP_W:0] E_SAT   = (BF16_EXP_W+1)'(BIAS + 15);

    state_t               state_q;
    logic [INT16_W-1:0]   mag_q;
    logic [2:0]           n_q;
    logic                 left_q;
    logic                 sign_q;
    logic [INT16_W-1:0]   y_q;
    logic                 ovf_q;

    logic [BF16_EXP_W-1:0] exp_f;
    logic [BF16_MAN_W-1:0] man_f;
    logic [BF16_EXP_W:0]   exp_w;

    // Decoded from the operand; only used on the accept edge.
    logic                  special_d;
    logic [INT16_W-1:0]    y_spec_d;
    logic                  ovf_spec_d;
    logic [2:0]            n_d;
    logic                  left_d;

    assign exp_f = bus.a[BF16_EXP_MSB:BF16_EXP_LSB];
    assign man_f = bus.a[BF16_MAN_W-1:0];
    assign exp_w = {1'b0, exp_f};

    always_comb begin
        special_d  = 1'b1;
        y_spec_d   = '0;
        ovf_spec_d = 1'b0;
        n_d        = 3'd0;
        left_d     = 1'b0;
        if (bus.a == BF16_NEG_32768) begin
            // Exactly representable minimum; not an overflow.
            y_spec_d = INT16_MIN;
        end else if (exp_f == '0) begin
            // zero / denormal -> 0
        end else if (exp_f == BF16_EXP_ALL_ONES) begin
            ovf_spec_d = 1'b1;
            if (man_f == '0) begin
                y_spec_d = bus.a[BF16_SIGN_POS] ? INT16_MIN : INT16_MAX;
            end
        end else if (exp_w < E_BIAS) begin
            // |a| < 1 truncates to 0
        end else if (exp_w >= E_SAT) begin
            ovf_spec_d = 1'b1;
            y_spec_d   = bus.a[BF16_SIGN_POS] ? INT16_MIN : INT16_MAX;
        end else begin
            // The hidden one sits at bit 7 of mag; the exponent decides how
            // far and which way it moves to reach its integer weight.
            special_d = 1'b0;
            left_d    = (exp_w >= E_PIVOT);
            n_d       = left_d ? 3'(exp_w - E_PIVOT) : 3'(E_PIVOT - exp_w);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mag_q   <= '0;
            n_q     <= 3'd0;
            left_q  <= 1'b0;
            sign_q  <= 1'b0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        sign_q <= bus.a[BF16_SIGN_POS];
                        mag_q  <= {8'b0, 1'b1, man_f};
                        if (special_d) begin
                            y_q     <= y_spec_d;
                            ovf_q   <= ovf_spec_d;
                            state_q <= ST_DONE;
                        end else begin
                            n_q     <= n_d;
                            left_q  <= left_d;
                            state_q <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (n_q != 3'd0) begin
                        // Right shifts drop low bits: truncation toward zero
                        // on the magnitude, applied before the sign.
                        mag_q <= left_q ? {mag_q[INT16_W-2:0], 1'b0}
                                        : {1'b0, mag_q[INT16_W-1:1]};
                        n_q   <= n_q - 3'd1;
                    end else begin
                        y_q     <= sign_q ? (~mag_q + 16'd1) : mag_q;
                        ovf_q   <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.y         = y_q;
    assign bus.overflow  = ovf_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_bf16_to_int16.sv
// tb_bf16_to_int16: directed-vector bench for bf16_to_int16. Inputs change
// 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_bf16_to_int16;
    import float_pkg::*;

    logic   clock;
    logic   reset;
    state_t dbg_state;

    int checks   = 0;
    int failures = 0;

    // expected {overflow, y}
    logic [16:0] exp_q[$];

    bf16_to_int16_if bus ();

    bf16_to_int16 #(.BIAS(127)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus.slave),
        .state_o (dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one operand, measure accept-to-out_valid edges (accept edge = 1),
    // optionally hold out_ready low for hold cycles, then take the result.
    task automatic run_op(input string tag, input logic [15:0] a_v, input logic [16:0] expv,
                          input int exp_lat, input int hold);
        logic [16:0] want;
        int lat;
        exp_q.push_back(expv);
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.a         = a_v;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            bus.a = 16'($urandom_range(0, 65535));
            tick();
            lat++;
        end
        want = exp_q.pop_front();
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".result"}, 32'({bus.overflow, bus.y}), 32'(want));
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                bus.a        = 16'h3F80;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            check({tag, ".hold_result"}, 32'({bus.overflow, bus.y}), 32'(want));
            check({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, ".back_idle_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".back_idle_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        reset         = 1'b0;
        bus.a         = 16'h0000;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();

        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.y", 32'(bus.y), 32'd0);
        check("rst.overflow", 32'(bus.overflow), 32'd0);
        check("rst.state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b1;
        tick();
        check("rst.in_ready", 32'(bus.in_ready), 32'd1);

        // normal path: n = |e - 134|, latency n + 2
        run_op("one",      16'h3F80, {1'b0, 16'h0001}, 9, 0);
        run_op("m2p5",     16'hC020, {1'b0, 16'hFFFE}, 8, 0);
        run_op("max_fit",  16'h46FF, {1'b0, 16'h7F80}, 9, 0);
        run_op("neg_fit",  16'hC6FF, {1'b0, 16'h8080}, 9, 0);
        run_op("three",    16'h4040, {1'b0, 16'h0003}, 8, 0);
        run_op("e134",     16'h4301, {1'b0, 16'h0081}, 2, 0);

        // special path: result on the accept edge
        run_op("sat_pos",  16'h4700, {1'b1, 16'h7FFF}, 1, 0);
        run_op("exact_min",16'hC700, {1'b0, 16'h8000}, 1, 0);
        run_op("sat_neg",  16'hC780, {1'b1, 16'h8000}, 1, 0);
        run_op("nan",      16'h7FC0, {1'b1, 16'h0000}, 1, 0);
        run_op("half",     16'h3F00, {1'b0, 16'h0000}, 1, 0);
        run_op("denorm",   16'h0001, {1'b0, 16'h0000}, 1, 0);
        run_op("neg_inf",  16'hFF80, {1'b1, 16'h8000}, 1, 0);
        run_op("pos_inf",  16'h7F80, {1'b1, 16'h7FFF}, 1, 0);

        // back-pressure: result held, stray in_valid pulse ignored
        run_op("hold", 16'h4000, {1'b0, 16'h0002}, 8, 5);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid || !bus.in_ready) seen++;
            tick();
        end
        check("hold.stray_ignored", 32'(seen), 32'd0);

        // reset in the middle of SHIFT
        bus.a        = 16'h3F80;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (2) tick();
        check("abort.in_shift", 32'(dbg_state), 32'(ST_SHIFT));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort.state", 32'(dbg_state), 32'(ST_IDLE));
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.out_valid) seen++;
            tick();
        end
        check("abort.no_valid", 32'(seen), 32'd0);
        run_op("after_abort", 16'h4000, {1'b0, 16'h0002}, 8, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
